// File: rtl/div_sequencer.sv
// ============================================================================
// Module      : div_sequencer
// Description : Front-end controller for a multi-cycle restoring divider.
//               Latches operands, runs the divider, sign-fixes the results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sequencer #(
    parameter bit          SIGNED     = 1'b1,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_err,
    output logic        div_control,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        hi_lo_write,
    output logic        done,
    output logic        div_zero,
    output logic        busy
);

    localparam int unsigned            c_cnt_w   = $clog2(DIV_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]     c_last    = c_cnt_w'(DIV_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]     c_cnt_one = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_q_neg;
    logic                 r_r_neg;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [31:0]          w_a_mag;
    logic [31:0]          w_b_mag;
    logic                 w_b_zero;

    // 0x80000000 negates to itself and is then used as an unsigned magnitude
    assign w_a_neg  = SIGNED & a_in[31];
    assign w_b_neg  = SIGNED & b_in[31];
    assign w_a_mag  = w_a_neg ? (~a_in + 32'd1) : a_in;
    assign w_b_mag  = w_b_neg ? (~b_in + 32'd1) : b_in;
    assign w_b_zero = (b_in == 32'd0);

    assign div_control = (r_state == S_RUN);
    assign busy        = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !w_b_zero) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (div_err) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_last) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            div_a       <= 32'd0;
            div_b       <= 32'd0;
            hi_out      <= 32'd0;
            lo_out      <= 32'd0;
            hi_lo_write <= 1'b0;
            done        <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            hi_lo_write <= 1'b0;
            done        <= 1'b0;
            div_zero    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_b_zero) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            div_a   <= w_a_mag;
                            div_b   <= w_b_mag;
                            r_q_neg <= w_a_neg ^ w_b_neg;
                            r_r_neg <= w_a_neg;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (div_err) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_CAPTURE: begin
                    lo_out      <= r_q_neg ? (~div_lo + 32'd1) : div_lo;
                    hi_out      <= r_r_neg ? (~div_hi + 32'd1) : div_hi;
                    hi_lo_write <= 1'b1;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
// Module      : tb_div_sequencer
// Description : Self-checking bench for div_sequencer, signed and unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        div_err = 1'b0;

    logic        ctl_s, hlw_s, done_s, dz_s, busy_s;
    logic [31:0] da_s, db_s, hi_s, lo_s;
    logic [31:0] dhi_s = 32'd0, dlo_s = 32'd0;
    int          dcnt_s = 0;

    logic        ctl_u, hlw_u, done_u, dz_u, busy_u;
    logic [31:0] da_u, db_u, hi_u, lo_u;
    logic [31:0] dhi_u = 32'd0, dlo_u = 32'd0;
    int          dcnt_u = 0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] eh_s = 32'd0, el_s = 32'd0, eh_u = 32'd0, el_u = 32'd0;

    always #5 clk = ~clk;

    div_sequencer #(.SIGNED(1'b1), .DIV_CYCLES(33)) u_dut_s (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .div_hi(dhi_s), .div_lo(dlo_s), .div_err(div_err),
        .div_control(ctl_s), .div_a(da_s), .div_b(db_s),
        .hi_out(hi_s), .lo_out(lo_s), .hi_lo_write(hlw_s),
        .done(done_s), .div_zero(dz_s), .busy(busy_s)
    );

    div_sequencer #(.SIGNED(1'b0), .DIV_CYCLES(33)) u_dut_u (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .div_hi(dhi_u), .div_lo(dlo_u), .div_err(div_err),
        .div_control(ctl_u), .div_a(da_u), .div_b(db_u),
        .hi_out(hi_u), .lo_out(lo_u), .hi_lo_write(hlw_u),
        .done(done_u), .div_zero(dz_u), .busy(busy_u)
    );

    // Divider stand-ins: result valid only after 33 enabled edges, garbage otherwise
    always @(posedge clk) begin
        if (!ctl_s) begin
            dcnt_s <= 0; dhi_s <= 32'hDEADBEEF; dlo_s <= 32'hBADC0FFE;
        end else begin
            dcnt_s <= dcnt_s + 1;
            if (dcnt_s == 32 && db_s != 32'd0) begin
                dlo_s <= da_s / db_s; dhi_s <= da_s % db_s;
            end
        end
    end

    always @(posedge clk) begin
        if (!ctl_u) begin
            dcnt_u <= 0; dhi_u <= 32'hDEADBEEF; dlo_u <= 32'hBADC0FFE;
        end else begin
            dcnt_u <= dcnt_u + 1;
            if (dcnt_u == 32 && db_u != 32'd0) begin
                dlo_u <= da_u / db_u; dhi_u <= da_u % db_u;
            end
        end
    end

    // Reference: truncating division on 64-bit integers, result taken mod 2^32
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
        longint sa, sb, q, r;
        if (sgn) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        a_in = a; b_in = b; start = 1'b1;
        tick();
        start = 1'b0; a_in = $urandom; b_in = $urandom;
    endtask

    task automatic wait_done(output int cyc, output int ctl);
        cyc = 0; ctl = 0;
        while (!(done_s || done_u) && cyc < 60) begin
            if (ctl_s) ctl++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_op(input logic [31:0] a, input logic [31:0] b, input string name);
        logic [63:0] rs, ru;
        int cyc, ctl;
        launch(a, b);
        if (b == 32'd0) begin
            n_checks++;
            if ({done_s, dz_s, hlw_s, busy_s, ctl_s} !== 5'b11000) begin
                n_errors++;
                $display("FAIL %s zero_flags_s: got %b expected 11000", name,
                         {done_s, dz_s, hlw_s, busy_s, ctl_s});
            end
            n_checks++;
            if ({done_u, dz_u, hlw_u, busy_u, ctl_u} !== 5'b11000) begin
                n_errors++;
                $display("FAIL %s zero_flags_u: got %b expected 11000", name,
                         {done_u, dz_u, hlw_u, busy_u, ctl_u});
            end
        end else begin
            rs = ref_div(a, b, 1'b1);
            ru = ref_div(a, b, 1'b0);
            n_checks++;
            if (busy_s !== 1'b1 || busy_u !== 1'b1) begin
                n_errors++;
                $display("FAIL %s busy_after_start: got %b%b expected 11", name, busy_s, busy_u);
            end
            wait_done(cyc, ctl);
            n_checks++;
            if (cyc !== 34) begin
                n_errors++;
                $display("FAIL %s latency: got %0d expected 34", name, cyc);
            end
            n_checks++;
            if (ctl !== 33) begin
                n_errors++;
                $display("FAIL %s div_control_edges: got %0d expected 33", name, ctl);
            end
            n_checks++;
            if ({done_s, dz_s, hlw_s, busy_s, done_u, dz_u, hlw_u, busy_u} !== 8'b1010_1010) begin
                n_errors++;
                $display("FAIL %s done_flags: got %b expected 10101010", name,
                         {done_s, dz_s, hlw_s, busy_s, done_u, dz_u, hlw_u, busy_u});
            end
            eh_s = rs[63:32]; el_s = rs[31:0];
            eh_u = ru[63:32]; el_u = ru[31:0];
        end
        n_checks++;
        if ({hi_s, lo_s} !== {eh_s, el_s}) begin
            n_errors++;
            $display("FAIL %s signed_hilo: got %h/%h expected %h/%h", name, hi_s, lo_s, eh_s, el_s);
        end
        n_checks++;
        if ({hi_u, lo_u} !== {eh_u, el_u}) begin
            n_errors++;
            $display("FAIL %s unsigned_hilo: got %h/%h expected %h/%h", name, hi_u, lo_u, eh_u, el_u);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if ({ctl_s, busy_s, done_s, dz_s, hlw_s, hi_s, lo_s, da_s, db_s} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got %h/%h/%h/%h ctl=%b busy=%b done=%b expected all 0",
                     hi_s, lo_s, da_s, db_s, ctl_s, busy_s, done_s);
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        test_op(32'd100, 32'd7, "100div7");
        test_op(32'hFFFFFFF9, 32'd2, "m7div2");
        test_op(32'd7, 32'hFFFFFFFE, "7divm2");
        test_op(32'hFFFFFFFF, 32'd2, "ffffdiv2");
        test_op(32'h80000000, 32'hFFFFFFFF, "overflow");
        test_op(32'h80000000, 32'h80000000, "minmin");
    endtask

    task automatic test_div_zero();
        test_op(32'd5, 32'd1, "load5div1");
        test_op(32'd9, 32'd0, "9div0");
        tick();
        n_checks++;
        if (done_s !== 1'b0 || dz_s !== 1'b0 || ctl_s !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_pulse_width: got done=%b dz=%b ctl=%b expected 000", done_s, dz_s, ctl_s);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = -($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            test_op(a, b, "random");
        end
    endtask

    task automatic test_ignore_start();
        logic [63:0] rs;
        int cyc, ndone;
        rs = ref_div(32'd1000, 32'd33, 1'b1);
        launch(32'd1000, 32'd33);
        cyc = 0; ndone = 0;
        while (cyc < 45) begin
            start = (cyc == 5 || cyc == 20);
            a_in  = $urandom;
            b_in  = (cyc == 20) ? 32'd0 : $urandom;
            tick();
            start = 1'b0;
            cyc++;
            if (done_s) begin
                ndone++;
                n_checks++;
                if (cyc !== 34 || {hi_s, lo_s} !== rs) begin
                    n_errors++;
                    $display("FAIL ignore_start_result: got cyc=%0d %h/%h expected 34 %h/%h",
                             cyc, hi_s, lo_s, rs[63:32], rs[31:0]);
                end
            end
        end
        n_checks++;
        if (ndone !== 1) begin
            n_errors++;
            $display("FAIL ignore_start_done_count: got %0d expected 1", ndone);
        end
        eh_s = rs[63:32]; el_s = rs[31:0];
        rs = ref_div(32'd1000, 32'd33, 1'b0);
        eh_u = rs[63:32]; el_u = rs[31:0];
    endtask

    task automatic test_back_to_back();
        test_op(32'd123456, 32'd789, "b2b_first");
        test_op(32'hFFFF0000, 32'd3, "b2b_second");
        test_op(32'd42, 32'd0, "b2b_zero");
        test_op(32'd42, 32'd5, "b2b_after_zero");
    endtask

    task automatic test_err_abort();
        launch(32'd77, 32'd3);
        repeat (10) tick();
        div_err = 1'b1;
        tick();
        div_err = 1'b0;
        n_checks++;
        if ({done_s, dz_s, hlw_s, busy_s, ctl_s, done_u, dz_u, hlw_u, busy_u, ctl_u} !== 10'b11000_11000) begin
            n_errors++;
            $display("FAIL err_abort_flags: got %b expected 1100011000",
                     {done_s, dz_s, hlw_s, busy_s, ctl_s, done_u, dz_u, hlw_u, busy_u, ctl_u});
        end
        n_checks++;
        if ({hi_s, lo_s, hi_u, lo_u} !== {eh_s, el_s, eh_u, el_u}) begin
            n_errors++;
            $display("FAIL err_abort_hold: got %h/%h expected %h/%h", hi_s, lo_s, eh_s, el_s);
        end
        tick();
        n_checks++;
        if (done_s !== 1'b0 || dz_s !== 1'b0) begin
            n_errors++;
            $display("FAIL err_abort_pulse: got done=%b dz=%b expected 00", done_s, dz_s);
        end
    endtask

    task automatic test_reset_midrun();
        int ndone;
        launch(32'd100, 32'd3);
        repeat (10) tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({ctl_s, busy_s, done_s, hlw_s, hi_s, lo_s, da_s, db_s,
             ctl_u, busy_u, done_u, hi_u, lo_u} !== '0) begin
            n_errors++;
            $display("FAIL midrun_reset: got ctl=%b busy=%b hi=%h lo=%h expected all 0",
                     ctl_s, busy_s, hi_s, lo_s);
        end
        eh_s = 32'd0; el_s = 32'd0; eh_u = 32'd0; el_u = 32'd0;
        repeat (2) tick();
        reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            tick();
            if (done_s || done_u) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_errors++;
            $display("FAIL midrun_reset_no_done: got %0d expected 0", ndone);
        end
        test_op(32'd50, 32'd5, "after_reset_50div5");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_err_abort();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
